// File: rtl/axi_line_writer.sv
// axi_line_writer: issues one 128-bit write-buffer line as a single 4-beat INCR AXI4 burst,
// then pulses done_o (with err_o) once the B response arrives.
module axi_line_writer #(
   parameter int              ID_W   = 4,
   parameter logic [ID_W-1:0] AXI_ID = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            wen_i,
   input  logic [31:0]     waddr_i,
   input  logic [127:0]    wdata_i,
   output logic            done_o,
   output logic            err_o,
   output logic            busy_o,
   output logic            awvalid,
   input  logic            awready,
   output logic [31:0]     awaddr,
   output logic [7:0]      awlen,
   output logic [2:0]      awsize,
   output logic [1:0]      awburst,
   output logic [ID_W-1:0] awid,
   output logic            wvalid,
   input  logic            wready,
   output logic [31:0]     wdata,
   output logic [3:0]      wstrb,
   output logic            wlast,
   input  logic            bvalid,
   output logic            bready,
   input  logic [1:0]      bresp
);
   typedef enum logic [2:0] {IDLE, AW, W, B, DONE} state_t;
   state_t       state, state_nx;
   logic [27:0]  addr_q;
   logic [127:0] line_q;
   logic [1:0]   cnt;
   logic         err_q;
   assign awlen   = 8'd3;
   assign awsize  = 3'b010;
   assign awburst = 2'b01;
   assign awid    = AXI_ID;
   assign wstrb   = 4'hF;
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = wen_i ? AW : IDLE;
         AW:      state_nx = awready ? W : AW;
         W:       state_nx = (wready && cnt == 2'd3) ? B : W;
         B:       state_nx = bvalid ? DONE : B;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end
   // The line is captured once per request, so input changes mid-burst cannot leak into beats.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q <= '0;
         line_q <= '0;
         cnt    <= '0;
         err_q  <= 1'b0;
      end else begin
         if (state == IDLE && wen_i) begin
            addr_q <= waddr_i[31:4];
            line_q <= wdata_i;
            cnt    <= '0;
         end
         if (state == W && wready) cnt <= cnt + 2'd1;
         if (state == B && bvalid) err_q <= bresp != 2'b00;
      end
   end
   always_comb begin
      awvalid = state == AW;
      wvalid  = state == W;
      wlast   = state == W && cnt == 2'd3;
      bready  = state == B;
      done_o  = state == DONE;
      err_o   = state == DONE && err_q;
      busy_o  = state != IDLE;
      awaddr  = {addr_q, 4'h0};
      wdata   = line_q[{cnt, 5'd0} +: 32];
   end
endmodule

// File: tb/tb_axi_line_writer.sv
// tb_axi_line_writer: table-driven and randomized line writes checked against a transaction-level model.
module tb_axi_line_writer;
   logic         clk = 1'b0;
   logic         rst, wen_i;
   logic [31:0]  waddr_i;
   logic [127:0] wdata_i;
   logic         done_o, err_o, busy_o;
   logic         awvalid, awready;
   logic [31:0]  awaddr;
   logic [7:0]   awlen;
   logic [2:0]   awsize;
   logic [1:0]   awburst;
   logic [3:0]   awid;
   logic         wvalid, wready, wlast;
   logic [31:0]  wdata;
   logic [3:0]   wstrb;
   logic         bvalid, bready;
   logic [1:0]   bresp;
   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [31:0]     addr;
      logic [127:0]    data;
      logic [1:0]      bresp;
      int              aws;
      logic [3:0][7:0] ws;
      int              bs;
      logic [31:0]     exp_awaddr;
      int              exp_lat;
      logic            exp_err;
   } vec_t;

   axi_line_writer #(.ID_W(4), .AXI_ID(4'd0)) dut (
      .clk(clk), .rst(rst), .wen_i(wen_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
      .done_o(done_o), .err_o(err_o), .busy_o(busy_o),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
      .awsize(awsize), .awburst(awburst), .awid(awid),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
      .bvalid(bvalid), .bready(bready), .bresp(bresp)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [31:0] addr, input logic [127:0] data, input logic [1:0] br,
                               input int aws, input logic [31:0] ws, input int bs,
                               input logic [31:0] ea, input int el, input logic ee);
      vec_t v;
      v.addr = addr; v.data = data; v.bresp = br; v.aws = aws; v.ws = ws; v.bs = bs;
      v.exp_awaddr = ea; v.exp_lat = el; v.exp_err = ee;
      return v;
   endfunction

   // Reference: address aligned down to 16 bytes, 7 cycles plus one per stall cycle, error on any non-OKAY.
   function automatic vec_t model(input vec_t v);
      vec_t r = v;
      r.exp_awaddr = v.addr - (v.addr % 16);
      r.exp_lat = 7 + v.aws + v.bs;
      for (int i = 0; i < 4; i++) r.exp_lat += int'(v.ws[i]);
      r.exp_err = v.bresp != 2'b00;
      return r;
   endfunction

   // Entered just after a negedge. chained: DUT is in DONE of the previous line with wen_i still high.
   task automatic run_line(input vec_t v, input bit chained, input bit keep);
      int n = 0;
      int beat = 0;
      int aw_left = v.aws;
      int b_left = v.bs;
      int wl[4];
      bit aw_done = 0;
      bit got_done = 0;
      for (int i = 0; i < 4; i++) wl[i] = int'(v.ws[i]);
      waddr_i = v.addr;
      wdata_i = v.data;
      wen_i = 1'b1;
      while (!got_done && n < 120) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (chained && n == 1) chk("idle_gap", busy_o, 0);
         if (n == 1 + int'(chained)) chk("aw_start", awvalid, 1);
         if (awvalid) begin
            chk("aw_once", aw_done, 0);
            chk("awaddr", awaddr, v.exp_awaddr);
            chk("aw_const", {awlen, awsize, awburst, awid}, {8'd3, 3'b010, 2'b01, 4'd0});
            awready = aw_left == 0;
            if (aw_left > 0) aw_left--;
            if (awready) begin
               aw_done = 1;
               wdata_i = 128'h1111;
               waddr_i = 32'h0BAD_0000;
            end
         end else awready = 1'($urandom);
         if (wvalid) begin
            chk("w_after_aw", aw_done, 1);
            chk("beat_range", beat < 4, 1);
            if (beat < 4) begin
               chk("wdata", wdata, v.data[32*beat +: 32]);
               chk("wlast", wlast, beat == 3);
               chk("wstrb", wstrb, 4'hF);
               wready = wl[beat] == 0;
               if (wl[beat] > 0) wl[beat]--;
               if (wready) beat++;
            end else wready = 1'b1;
         end else wready = 1'($urandom);
         if (bready) begin
            chk("b_after_w", beat, 4);
            bvalid = b_left == 0;
            bresp = bvalid ? v.bresp : 2'($urandom);
            if (b_left > 0) b_left--;
         end else begin
            bvalid = 1'($urandom);
            bresp = 2'($urandom);
         end
         if (done_o) begin
            got_done = 1;
            chk("done_lat", n, v.exp_lat + int'(chained));
            chk("err", err_o, v.exp_err);
            chk("beats", beat, 4);
         end
      end
      chk("done_seen", got_done, 1);
      if (!keep) begin
         wen_i = 1'b0;
         @(posedge clk);
         @(negedge clk);
         chk("done_pulse", done_o, 0);
         chk("back_idle", busy_o, 0);
      end
   endtask

   initial begin
      vec_t tbl[6];
      vec_t v;
      logic [127:0] d;
      bit keep, chained;
      bit found;
      int dones;
      tbl[0] = mk(32'h24687571, 128'h34567891_02345678_91023456_78910234, 2'b00, 0, 32'h0, 0, 32'h24687570, 7, 1'b0);
      tbl[1] = mk(32'h10000008, 128'hA0A0A0A0_B1B1B1B1_C2C2C2C2_D3D3D3D3, 2'b00, 3, 32'h00020000, 5, 32'h10000000, 17, 1'b0);
      tbl[2] = mk(32'hDEADBEEF, 128'h01234567_89ABCDEF_FEDCBA98_76543210, 2'b10, 0, 32'h0, 0, 32'hDEADBEE0, 7, 1'b1);
      tbl[3] = mk(32'h0000001F, 128'h55555555_AAAAAAAA_33333333_CCCCCCCC, 2'b00, 0, 32'h0, 0, 32'h00000010, 7, 1'b0);
      tbl[4] = mk(32'h8000_0004, 128'h11112222_33334444_55556666_77778888, 2'b01, 0, 32'h01010101, 0, 32'h80000000, 11, 1'b1);
      tbl[5] = mk(32'hFFFFFFFF, 128'hFFFFFFFF_00000000_FFFFFFFF_00000001, 2'b00, 1, 32'h0, 2, 32'hFFFFFFF0, 10, 1'b0);
      rst = 1'b1; wen_i = 1'b0; waddr_i = '0; wdata_i = '0;
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_outs", {awvalid, wvalid, wlast, bready, done_o, err_o, busy_o}, 0);
      chk("rst_awaddr", awaddr, 0);
      chk("rst_wdata", wdata, 0);
      chk("rst_const", {awlen, awsize, awburst, awid, wstrb}, {8'd3, 3'b010, 2'b01, 4'd0, 4'hF});
      rst = 1'b0;
      for (int i = 0; i < 6; i++) run_line(tbl[i], 1'b0, 1'b0);
      // back-to-back lines with wen_i held high and data swapped on done_o
      run_line(tbl[0], 1'b0, 1'b1);
      run_line(tbl[3], 1'b1, 1'b0);
      // reset while beat 2 is on the bus
      d = 128'hCAFEF00D_BEEF0002_12345601_0BADC0DE;
      waddr_i = 32'h40000040; wdata_i = d; wen_i = 1'b1;
      awready = 1'b1; wready = 1'b1; bvalid = 1'b0;
      found = 0;
      for (int k = 0; k < 20 && !found; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (wvalid && wdata == d[95:64]) found = 1;
      end
      chk("rst_reach_beat2", found, 1);
      rst = 1'b1; wen_i = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("midrst_outs", {awvalid, wvalid, wlast, bready, done_o, err_o, busy_o}, 0);
      chk("midrst_awaddr", awaddr, 0);
      chk("midrst_wdata", wdata, 0);
      rst = 1'b0; bvalid = 1'b1;
      dones = 0;
      repeat (10) begin
         @(posedge clk);
         @(negedge clk);
         if (done_o || busy_o) dones++;
      end
      chk("midrst_quiet", dones, 0);
      bvalid = 1'b0;
      run_line(tbl[1], 1'b0, 1'b0);
      // randomized lines, some chained back-to-back
      chained = 0;
      for (int i = 0; i < 40; i++) begin
         v.addr = $urandom;
         v.data = {$urandom, $urandom, $urandom, $urandom};
         v.bresp = 2'($urandom);
         v.aws = $urandom_range(0, 3);
         for (int j = 0; j < 4; j++) v.ws[j] = 8'($urandom_range(0, 2));
         v.bs = $urandom_range(0, 3);
         v = model(v);
         keep = (i < 39) ? 1'($urandom) : 1'b0;
         run_line(v, chained, keep);
         chained = keep;
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
